// File: rtl/ofmap_output_buffer.sv
// ofmap_output_buffer: captures 9-lane PE results into an OFMAP store, then
// streams the full OUT_H x OUT_W map in raster order over valid/ready.
// Optional build macro: OFMAP_RELU_EN (clamp negative lane values to 0 at capture).
module ofmap_output_buffer #(
  parameter int WIDTH        = 4,
  parameter int INPUT_WIDTH  = 9,
  parameter int INPUT_HEIGHT = 9,
  parameter int KERNEL_SIZE  = 3,
  parameter int PADDING_SIZE = 0,
  parameter int STRIDE       = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 output_buffer_enable,
  input  logic [WIDTH*3-1:0]   final_output_1,
  input  logic [WIDTH*3-1:0]   final_output_2,
  input  logic [WIDTH*3-1:0]   final_output_3,
  input  logic [WIDTH*3-1:0]   final_output_4,
  input  logic [WIDTH*3-1:0]   final_output_5,
  input  logic [WIDTH*3-1:0]   final_output_6,
  input  logic [WIDTH*3-1:0]   final_output_7,
  input  logic [WIDTH*3-1:0]   final_output_8,
  input  logic [WIDTH*3-1:0]   final_output_9,
  output logic [WIDTH*3-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [15:0]          fill_count,
  output logic                 busy,
  output logic                 overflow
);

  localparam int EW      = WIDTH * 3;
  localparam int LANES   = 9;
  localparam int OUT_W   = (INPUT_WIDTH - KERNEL_SIZE + 2 * PADDING_SIZE) / STRIDE + 1;
  localparam int OUT_H   = (INPUT_HEIGHT - KERNEL_SIZE + 2 * PADDING_SIZE) / STRIDE + 1;
  localparam int DEPTH   = OUT_W * OUT_H;
  localparam int NBATCH  = (DEPTH + LANES - 1) / LANES;
  // Keeps declarations well-formed while the legality check reports the error.
  localparam int DEPTH_S = (DEPTH < 1) ? 1 : DEPTH;
  localparam int PTR_W   = $clog2(DEPTH_S + 1);
  localparam int MEM_AW  = (DEPTH_S > 1) ? $clog2(DEPTH_S) : 1;

  // Reject geometries that produce an empty output map.
  if (OUT_W < 1 || OUT_H < 1 || DEPTH < 1) begin : g_bad_depth
    $error("ofmap_output_buffer: DEPTH must be at least 1");
  end
  if (NBATCH * LANES < DEPTH) begin : g_bad_nbatch
    $error("ofmap_output_buffer: batch count cannot cover DEPTH");
  end

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t            state;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_next;
  logic              load;
  logic              last_hs;
  logic [EW-1:0]     mem [DEPTH_S];
  logic [EW-1:0]     lane [LANES];
  logic [EW-1:0]     lane_cap [LANES];

`ifdef OFMAP_RELU_EN
  // Signed clamp: negative values are stored as zero.
  function automatic logic [EW-1:0] capture_val(input logic [EW-1:0] v);
    return v[EW-1] ? '0 : v;
  endfunction
`endif

  // Gather the lane ports into an array and apply the optional capture transform.
  always_comb begin
    lane[0] = final_output_1;
    lane[1] = final_output_2;
    lane[2] = final_output_3;
    lane[3] = final_output_4;
    lane[4] = final_output_5;
    lane[5] = final_output_6;
    lane[6] = final_output_7;
    lane[7] = final_output_8;
    lane[8] = final_output_9;
    for (int k = 0; k < LANES; k++) begin
`ifdef OFMAP_RELU_EN
      lane_cap[k] = capture_val(lane[k]);
`else
      lane_cap[k] = lane[k];
`endif
    end
  end

  // Next write pointer saturates at DEPTH; surplus lanes of the last batch are dropped.
  always_comb begin
    wr_next = wr_ptr;
    if (int'(wr_ptr) + LANES <= DEPTH) begin
      wr_next = wr_ptr + PTR_W'(LANES);
    end else begin
      wr_next = PTR_W'(DEPTH);
    end
  end

  // Output register reload condition and end-of-frame handshake.
  always_comb begin
    load    = (state == DRAIN) && (!out_valid || out_ready) && (int'(rd_ptr) < DEPTH);
    last_hs = (state == DRAIN) && out_valid && out_ready && out_last;
  end

  // OFMAP storage writes; contents need no reset.
  always_ff @(posedge clk) begin
    if (!reset && state == FILL && output_buffer_enable) begin
      for (int k = 0; k < LANES; k++) begin
        if (int'(wr_ptr) + k < DEPTH) begin
          mem[MEM_AW'(int'(wr_ptr) + k)] <= lane_cap[k];
        end
      end
    end
  end

  // FILL/DRAIN control with registered stream outputs and status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FILL;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      fill_count <= '0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (output_buffer_enable) begin
            wr_ptr     <= wr_next;
            fill_count <= 16'(wr_next);
            if (wr_next == PTR_W'(DEPTH)) begin
              state  <= DRAIN;
              busy   <= 1'b1;
              rd_ptr <= '0;
            end
          end
        end
        DRAIN: begin
          // Any capture attempt while the map is being drained is lost.
          if (output_buffer_enable) begin
            overflow <= 1'b1;
          end
          if (last_hs) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            state      <= FILL;
            wr_ptr     <= '0;
            fill_count <= '0;
            busy       <= 1'b0;
          end else if (load) begin
            out_data  <= mem[MEM_AW'(rd_ptr)];
            out_valid <= 1'b1;
            out_last  <= (rd_ptr == PTR_W'(DEPTH - 1));
            rd_ptr    <= rd_ptr + PTR_W'(1);
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ofmap_output_buffer.sv
// Directed bench for ofmap_output_buffer: default 7x7 map and a 4x4 map instance.
module tb_ofmap_output_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        strobe_a, ready_a, valid_a, last_a, busy_a, ovf_a;
  logic        strobe_b, ready_b, valid_b, last_b, busy_b, ovf_b;
  logic [11:0] lane_a [9];
  logic [11:0] lane_b [9];
  logic [11:0] data_a, data_b;
  logic [15:0] fc_a, fc_b;

  int tests = 0;
  int fails = 0;
  int expd [64];
  bit relu_vec = 1'b0;

  ofmap_output_buffer u_dut_a (
    .clk(clk), .reset(reset), .output_buffer_enable(strobe_a),
    .final_output_1(lane_a[0]), .final_output_2(lane_a[1]), .final_output_3(lane_a[2]),
    .final_output_4(lane_a[3]), .final_output_5(lane_a[4]), .final_output_6(lane_a[5]),
    .final_output_7(lane_a[6]), .final_output_8(lane_a[7]), .final_output_9(lane_a[8]),
    .out_data(data_a), .out_valid(valid_a), .out_ready(ready_a), .out_last(last_a),
    .fill_count(fc_a), .busy(busy_a), .overflow(ovf_a)
  );

  ofmap_output_buffer #(.INPUT_WIDTH(6), .INPUT_HEIGHT(6), .KERNEL_SIZE(3)) u_dut_b (
    .clk(clk), .reset(reset), .output_buffer_enable(strobe_b),
    .final_output_1(lane_b[0]), .final_output_2(lane_b[1]), .final_output_3(lane_b[2]),
    .final_output_4(lane_b[3]), .final_output_5(lane_b[4]), .final_output_6(lane_b[5]),
    .final_output_7(lane_b[6]), .final_output_8(lane_b[7]), .final_output_9(lane_b[8]),
    .out_data(data_b), .out_valid(valid_b), .out_ready(ready_b), .out_last(last_b),
    .fill_count(fc_b), .busy(busy_b), .overflow(ovf_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_expd_ramp();
    for (int i = 0; i < 64; i++) expd[i] = i;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    strobe_a = 1'b0; strobe_b = 1'b0;
    ready_a = 1'b0; ready_b = 1'b0;
    for (int n = 0; n < 9; n++) begin
      lane_a[n] = '0;
      lane_b[n] = '0;
    end
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One strobe every 3 cycles; lane n of batch b carries 9*b+n.
  task automatic send_frame(input int which, input int nb, input int depth);
    int exp_fc;
    logic [15:0] fc;
    for (int b = 0; b < nb; b++) begin
      for (int n = 0; n < 9; n++) begin
        logic [11:0] v;
        v = 12'(9 * b + n);
        if (relu_vec && b == 0 && n == 0) v = 12'hFFF;
        if (relu_vec && b == 0 && n == 1) v = 12'h7FF;
        if (which == 0) lane_a[n] = v; else lane_b[n] = v;
      end
      if (which == 0) strobe_a = 1'b1; else strobe_b = 1'b1;
      tick();
      strobe_a = 1'b0; strobe_b = 1'b0;
      exp_fc = (9 * (b + 1) < depth) ? 9 * (b + 1) : depth;
      fc = (which == 0) ? fc_a : fc_b;
      tests++;
      if (fc !== 16'(exp_fc)) begin
        fails++;
        $display("FAIL fill_count dut%0d batch %0d: got %0d expected %0d", which, b, fc, exp_fc);
      end
      if (b < nb - 1) begin
        tick();
        tick();
      end
    end
  endtask

  // Called right after the final strobe edge: first valid exactly one cycle later.
  task automatic check_drain_start(input int which);
    logic v, bz;
    logic [11:0] d;
    v = (which == 0) ? valid_a : valid_b;
    bz = (which == 0) ? busy_a : busy_b;
    tests++;
    if (v !== 1'b0 || bz !== 1'b1) begin
      fails++;
      $display("FAIL drain_entry dut%0d: valid=%b busy=%b expected valid=0 busy=1", which, v, bz);
    end
    tick();
    v = (which == 0) ? valid_a : valid_b;
    d = (which == 0) ? data_a : data_b;
    tests++;
    if (v !== 1'b1 || d !== 12'(expd[0])) begin
      fails++;
      $display("FAIL first_out_latency dut%0d: valid=%b data=%0d expected valid=1 data=%0d",
               which, v, d, expd[0]);
    end
  endtask

  // Drain the stream; mode 0 = ready always high, mode 1 = ready pattern 1,0,0,1.
  task automatic collect(input int which, input int mode, input int n_exp);
    logic v, l, rdy, held, bz;
    logic [11:0] d, hd;
    logic [15:0] fc;
    int got, cyc;
    got = 0; cyc = 0; held = 1'b0; hd = '0;
    while (got < n_exp && cyc < 1000) begin
      rdy = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (which == 0) ready_a = rdy; else ready_b = rdy;
      v = (which == 0) ? valid_a : valid_b;
      l = (which == 0) ? last_a : last_b;
      d = (which == 0) ? data_a : data_b;
      if (held) begin
        tests++;
        if (v !== 1'b1 || d !== hd) begin
          fails++;
          $display("FAIL stall_stability dut%0d cyc %0d: valid=%b data=%0d expected valid=1 data=%0d",
                   which, cyc, v, d, hd);
        end
      end
      if (v === 1'b1 && rdy) begin
        tests++;
        if (d !== 12'(expd[got]) || l !== (got == n_exp - 1)) begin
          fails++;
          $display("FAIL stream dut%0d elem %0d: data=%0d last=%b expected data=%0d last=%b",
                   which, got, d, l, expd[got], (got == n_exp - 1));
        end
        got++;
      end
      held = v && !rdy;
      hd = d;
      tick();
      cyc++;
    end
    ready_a = 1'b0; ready_b = 1'b0;
    tests++;
    if (got != n_exp) begin
      fails++;
      $display("FAIL stream_count dut%0d: got %0d elements expected %0d", which, got, n_exp);
    end
    if (mode == 0) begin
      tests++;
      if (cyc != n_exp) begin
        fails++;
        $display("FAIL full_rate dut%0d: %0d cycles expected %0d", which, cyc, n_exp);
      end
    end
    v = (which == 0) ? valid_a : valid_b;
    l = (which == 0) ? last_a : last_b;
    bz = (which == 0) ? busy_a : busy_b;
    fc = (which == 0) ? fc_a : fc_b;
    tests++;
    if (v !== 1'b0 || l !== 1'b0 || bz !== 1'b0 || fc !== 16'd0) begin
      fails++;
      $display("FAIL end_of_drain dut%0d: valid=%b last=%b busy=%b fill=%0d expected all 0",
               which, v, l, bz, fc);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (data_a !== 12'd0 || valid_a !== 1'b0 || last_a !== 1'b0 || fc_a !== 16'd0 ||
        busy_a !== 1'b0 || ovf_a !== 1'b0) begin
      fails++;
      $display("FAIL reset_state_a: data=%0d valid=%b last=%b fill=%0d busy=%b ovf=%b expected all 0",
               data_a, valid_a, last_a, fc_a, busy_a, ovf_a);
    end
    tests++;
    if (data_b !== 12'd0 || valid_b !== 1'b0 || fc_b !== 16'd0 || busy_b !== 1'b0 ||
        ovf_b !== 1'b0) begin
      fails++;
      $display("FAIL reset_state_b: data=%0d valid=%b fill=%0d busy=%b ovf=%b expected all 0",
               data_b, valid_b, fc_b, busy_b, ovf_b);
    end
  endtask

  task automatic test_stream_full_rate();
    set_expd_ramp();
    send_frame(0, 6, 49);
    check_drain_start(0);
    collect(0, 0, 49);
  endtask

  task automatic test_backpressure();
    set_expd_ramp();
    send_frame(0, 6, 49);
    check_drain_start(0);
    collect(0, 1, 49);
  endtask

  task automatic test_overflow();
    set_expd_ramp();
    send_frame(0, 6, 49);
    for (int n = 0; n < 9; n++) lane_a[n] = 12'hABC;
    strobe_a = 1'b1;
    tick();
    strobe_a = 1'b0;
    tests++;
    if (ovf_a !== 1'b1) begin
      fails++;
      $display("FAIL overflow_set: got %b expected 1", ovf_a);
    end
    collect(0, 0, 49);
    tests++;
    if (ovf_a !== 1'b1) begin
      fails++;
      $display("FAIL overflow_sticky: got %b expected 1", ovf_a);
    end
    send_frame(0, 6, 49);
    check_drain_start(0);
    collect(0, 1, 49);
    tests++;
    if (ovf_a !== 1'b1) begin
      fails++;
      $display("FAIL overflow_sticky_frame2: got %b expected 1", ovf_a);
    end
  endtask

  task automatic test_reset_mid_fill();
    do_reset();
    tests++;
    if (ovf_a !== 1'b0) begin
      fails++;
      $display("FAIL overflow_cleared: got %b expected 0", ovf_a);
    end
    set_expd_ramp();
    send_frame(0, 3, 49);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (fc_a !== 16'd0 || valid_a !== 1'b0 || busy_a !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_fill: fill=%0d valid=%b busy=%b expected 0 0 0", fc_a, valid_a, busy_a);
    end
    send_frame(0, 6, 49);
    check_drain_start(0);
    collect(0, 0, 49);
  endtask

  task automatic test_relu();
    set_expd_ramp();
`ifdef OFMAP_RELU_EN
    expd[0] = 0;
`else
    expd[0] = 4095;
`endif
    expd[1] = 2047;
    relu_vec = 1'b1;
    send_frame(0, 6, 49);
    relu_vec = 1'b0;
    check_drain_start(0);
    collect(0, 0, 49);
    set_expd_ramp();
  endtask

  task automatic test_small_map();
    set_expd_ramp();
    send_frame(1, 2, 16);
    check_drain_start(1);
    collect(1, 0, 16);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream_full_rate();
    test_backpressure();
    test_overflow();
    test_reset_mid_fill();
    test_relu();
    test_small_map();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ofmap_output_buffer.md
Name: ofmap_output_buffer

Overview:
- Sits between the 9-lane PE array and the pooling unit.
- Each time output_buffer_enable pulses, it captures one 9-element batch of output-feature-map (OFMAP) results (final_output_1..9) into an internal OFMAP memory.
- Once the full OUT_H x OUT_W map is captured, it streams the elements in raster order over a valid/ready interface, so the pooling stage never has to guess when storage is full.

Parameters:
- WIDTH, 4: base width; each OFMAP element is WIDTH*3 bits.
- INPUT_WIDTH, 9: input feature map width.
- INPUT_HEIGHT, 9: input feature map height.
- KERNEL_SIZE, 3: square kernel size.
- PADDING_SIZE, 0: zero padding per side.
- STRIDE, 1: convolution stride.
- Derived locals (not overridable):
  - OUT_W = (INPUT_WIDTH-KERNEL_SIZE+2*PADDING_SIZE)/STRIDE+1
  - OUT_H likewise from INPUT_HEIGHT
  - DEPTH = OUT_W*OUT_H (49 at defaults)
  - NBATCH = ceil(DEPTH/9) (6 at defaults)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- output_buffer_enable  input  1  one-cycle capture strobe; lanes valid this cycle
- final_output_1 .. final_output_9  input  WIDTH*3 each  PE lane results; lane n holds element 9*b+(n-1) of batch b
- out_data  output  WIDTH*3  streamed OFMAP element
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts when out_valid&&out_ready
- out_last  output  1  high with element DEPTH-1
- fill_count  output  16  elements currently captured (0..DEPTH)
- busy  output  1  high in DRAIN state
- overflow  output  1  sticky; a capture was dropped

Behaviour:
- Reset: one clock and one synchronous active-high reset. On reset:
  - out_data=0, out_valid=0, out_last=0, fill_count=0, busy=0, overflow=0
  - state=FILL, wr_ptr=0, rd_ptr=0
  - Memory contents are don't-care. Reset wins over every other input in the same cycle, including mid-FILL and mid-DRAIN.
- FSM has two states, FILL and DRAIN.
- FILL, strobe high in a cycle:
  - Write lane n to mem[wr_ptr+n-1] for every lane where wr_ptr+n-1 < DEPTH.
  - Lanes at or beyond DEPTH are discarded; there is no wrap into address 0.
  - wr_ptr += min(9, DEPTH-wr_ptr); fill_count tracks wr_ptr.
  - If the new wr_ptr == DEPTH, the state becomes DRAIN next cycle and rd_ptr=0.
- FILL, strobe low: hold.
- DRAIN:
  - busy=1.
  - Output register is loaded when (!out_valid || out_ready) and rd_ptr < DEPTH: out_data=mem[rd_ptr], out_valid=1, out_last=(rd_ptr==DEPTH-1), rd_ptr+=1.
  - First out_valid appears one cycle after entering DRAIN; the worst-case capture-to-first-output latency is 2 cycles after the final strobe.
  - While out_valid && !out_ready, out_data and out_last must stay stable.
  - Full-rate streaming: one element per cycle when out_ready is held high.
- End of drain: on the handshake of the element carrying out_last:
  - Next cycle: out_valid=0, out_last=0, state=FILL, wr_ptr=0, fill_count=0, busy=0.
  - A new frame may be captured from that cycle on.
- Strobe during DRAIN, or in the cycle of the last handshake: batch dropped, overflow set to 1. overflow is cleared only by reset.
- Arithmetic and data path:
  - Data is passed through unmodified unless the optional feature is enabled.
  - Pointers are wide enough for DEPTH; fill_count is zero-extended to 16 bits.
- Parameter legality: DEPTH < 1 is illegal and must raise an elaboration error.

Optional Feature:
- Macro OFMAP_RELU_EN.
- When defined: each lane value is treated as signed two's complement at capture time; if its MSB is 1 the value 0 is stored instead. No added latency.
- When undefined: values are stored raw.

Test Plan:
- Defaults, lane value = 9*b+(n-1) for b=0..5, one strobe every 3 cycles, out_ready=1 -> out_data streams 0..48 consecutively, out_last only with 48, lanes 5..9 of batch 5 (values 49..53) never appear, fill_count reaches 49 then returns to 0.
- Same fill, out_ready toggling 1,0,0,1 -> every element appears exactly once in order; out_data is stable whenever out_valid=1 and out_ready=0.
- Strobe asserted during DRAIN with lanes=12'hABC -> overflow=1 and stays 1; streamed data is unchanged (0..48); the next frame still captures correctly.
- Reset pulsed after 3 of 6 strobes -> fill_count=0, out_valid=0; a full new frame then streams 0..48 correctly.
- Lane 1 = 12'hFFF, lane 2 = 12'h7FF in batch 0 -> element 0 reads 0 with OFMAP_RELU_EN defined and 4095 without; element 1 reads 2047 in both cases.
- INPUT_WIDTH=INPUT_HEIGHT=6, KERNEL_SIZE=3 (DEPTH=16, two strobes) -> 16 elements out; lanes 8..9 of the second strobe are discarded; out_last is high with element 15.
